// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART: register offsets, STATUS/CTRL bit positions and FSM state types.
package apb_uart_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_BAUD   = 4'hC;

  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_PAR_ERR   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_RX_OVR    = 6;

  localparam int CT_TX_EN       = 0;
  localparam int CT_RX_EN       = 1;
  localparam int CT_IE_RX_AVAIL = 2;
  localparam int CT_IE_TX_EMPTY = 3;
  localparam int CT_IE_ERR      = 4;
  localparam int CT_PAR_ODD     = 5;
  localparam int CT_PAR_EN      = 6;

  // Sticky flag vector is STATUS[6:4] shifted down
  localparam int STICKY_PAR   = 0;
  localparam int STICKY_FRAME = 1;
  localparam int STICKY_OVR   = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port; overflowing pushes and empty pops are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push to a full FIFO is accepted alongside it
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_uart_v2.sv
// APB slave UART with TX/RX FIFOs, x16 oversampled receiver, sticky errors and maskable interrupt.
// Define UART_PARITY_EN to add the parity bit and CTRL[6:5] {par_en, par_odd}.
module apb_uart_v2
  import apb_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  output logic [31:0]       prdata_o,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic              urxd_i,
  output logic              utxd_o,
  output logic              uart_int_o
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_PARITY_EN
  localparam int CTRL_W = 7;
`else
  localparam int CTRL_W = 5;
`endif

  logic              sel_data, sel_status, sel_ctrl, sel_baud;
  logic              apb_wr, apb_rd_setup, apb_rd_access;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DIV_W-1:0]  baud_q, baud_d, bcnt_q, bcnt_d;
  logic [2:0]        sticky_q, sticky_d;
  logic [31:0]       prdata_q, prdata_d;
  logic [6:0]        status;
  logic              tick, tx_en, rx_en, par_en, par_odd;
  logic              unused_pwdata;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] tx_rdata, rx_rdata;
  logic [CNT_W-1:0]     tx_count_unused, rx_count_unused;

  tx_state_e            tx_state_q, tx_state_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 txd_q, txd_d, tx_load, tx_par_bit;

  rx_state_e            rx_state_q, rx_state_d;
  logic [3:0]           rx_tcnt_q, rx_tcnt_d, rx_last;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic                 rx_set_par, rx_set_frame, rx_set_ovr;

  assign sel_data      = (paddr_i == ADDR_W'(OFF_DATA));
  assign sel_status    = (paddr_i == ADDR_W'(OFF_STATUS));
  assign sel_ctrl      = (paddr_i == ADDR_W'(OFF_CTRL));
  assign sel_baud      = (paddr_i == ADDR_W'(OFF_BAUD));
  assign apb_wr        = psel_i & penable_i & pwrite_i;
  assign apb_rd_setup  = psel_i & ~penable_i & ~pwrite_i;
  assign apb_rd_access = psel_i & penable_i & ~pwrite_i;
  assign unused_pwdata = ^pwdata_i;

  assign tx_en = ctrl_q[CT_TX_EN];
  assign rx_en = ctrl_q[CT_RX_EN];
`ifdef UART_PARITY_EN
  assign par_en  = ctrl_q[CT_PAR_EN];
  assign par_odd = ctrl_q[CT_PAR_ODD];
`else
  assign par_en  = 1'b0;
  assign par_odd = 1'b0;
`endif

  assign status     = {sticky_q, rx_full, rx_empty, tx_full, tx_empty};
  assign tx_push    = apb_wr & sel_data;
  assign rx_pop     = apb_rd_access & sel_data;
  assign rx_set_ovr = rx_push & rx_full & ~rx_pop;
  assign tx_pop     = tx_load;
  assign utxd_o     = txd_q;
  assign prdata_o   = prdata_q;
  assign uart_int_o = (ctrl_q[CT_IE_RX_AVAIL] & ~rx_empty) | (ctrl_q[CT_IE_TX_EMPTY] & tx_empty) |
                      (ctrl_q[CT_IE_ERR] & (|sticky_q));

  // Baud tick: down-counter reloads from BAUD, giving one tick every BAUD clocks
  assign tick   = (bcnt_q <= DIV_W'(1));
  assign bcnt_d = tick ? baud_q : bcnt_q - DIV_W'(1);

  always_comb begin
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    sticky_d = sticky_q;
    prdata_d = prdata_q;
    if (apb_wr && sel_ctrl) ctrl_d = pwdata_i[CTRL_W-1:0];
    if (apb_wr && sel_baud) baud_d = (pwdata_i[DIV_W-1:0] == '0) ? DIV_W'(1) : pwdata_i[DIV_W-1:0];
    if (apb_wr && sel_status) sticky_d = sticky_q & ~pwdata_i[ST_RX_OVR:ST_PAR_ERR];
    if (rx_set_par)   sticky_d[STICKY_PAR]   = 1'b1;
    if (rx_set_frame) sticky_d[STICKY_FRAME] = 1'b1;
    if (rx_set_ovr)   sticky_d[STICKY_OVR]   = 1'b1;
    if (apb_rd_setup) begin
      prdata_d = '0;
      if (sel_data)        prdata_d = rx_empty ? 32'd0 : 32'(rx_rdata);
      else if (sel_status) prdata_d = 32'(status);
      else if (sel_ctrl)   prdata_d = 32'(ctrl_q);
      else if (sel_baud)   prdata_d = 32'(baud_q);
    end
  end

  // Transmitter: every bit lasts 16 ticks; a pending byte chains straight after the stop bit
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    if (tick) begin
      if (tx_state_q == TX_IDLE) begin
        tx_load = tx_en & ~tx_empty;
      end else if (tx_tcnt_q != 4'd15) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
      end else begin
        tx_tcnt_d = '0;
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
            txd_d      = tx_sh_q[0];
          end
          TX_DATA: begin
            if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
              tx_state_d = par_en ? TX_PARITY : TX_STOP;
              txd_d      = par_en ? tx_par_bit : 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + BIT_W'(1);
              tx_sh_d  = tx_sh_q >> 1;
              txd_d    = tx_sh_q[1];
            end
          end
          TX_PARITY: begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end
          TX_STOP: begin
            if (tx_en && !tx_empty) tx_load = 1'b1;
            else tx_state_d = TX_IDLE;
          end
          default: tx_state_d = TX_IDLE;
        endcase
      end
    end
    if (tx_load) begin
      tx_state_d = TX_START;
      tx_tcnt_d  = '0;
      tx_sh_d    = tx_rdata;
      txd_d      = 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  logic tx_par_q, tx_par_d;
  assign tx_par_bit = tx_par_q;
  assign tx_par_d   = tx_load ? ((^tx_rdata) ^ par_odd) : tx_par_q;
  always_ff @(posedge clk) tx_par_q <= tx_par_d;
`else
  assign tx_par_bit = 1'b0;
`endif

  // Receiver: start bit confirmed at its centre, later bits sampled every 16 ticks from there
  assign rx_last = (rx_state_q == RX_START) ? 4'd7 : 4'd15;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tcnt_d    = rx_tcnt_q;
    rx_bit_d     = rx_bit_q;
    rx_sh_d      = rx_sh_q;
    rx_push      = 1'b0;
    rx_set_par   = 1'b0;
    rx_set_frame = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      if (rx_en && rxd_prev_q && !rxd_s2_q) begin
        rx_state_d = RX_START;
        rx_tcnt_d  = '0;
      end
    end else if (tick) begin
      if (rx_tcnt_q != rx_last) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
      end else begin
        rx_tcnt_d = '0;
        case (rx_state_q)
          RX_START: begin
            rx_bit_d   = '0;
            rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
          end
          RX_DATA: begin
            rx_sh_d = {rxd_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_W'(DATA_BITS - 1)) rx_state_d = par_en ? RX_PARITY : RX_STOP;
            else rx_bit_d = rx_bit_q + BIT_W'(1);
          end
          RX_PARITY: begin
            rx_set_par = (rxd_s2_q != ((^rx_sh_q) ^ par_odd));
            rx_state_d = RX_STOP;
          end
          RX_STOP: begin
            rx_state_d = RX_IDLE;
            if (rxd_s2_q) rx_push = 1'b1;
            else rx_set_frame = 1'b1;
          end
          default: rx_state_d = RX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ctrl_q     <= '0;
      baud_q     <= DIV_W'(1);
      bcnt_q     <= DIV_W'(1);
      sticky_q   <= '0;
      prdata_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      bcnt_q     <= bcnt_d;
      sticky_q   <= sticky_d;
      prdata_q   <= prdata_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rxd_s1_q   <= urxd_i;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (pwdata_i[DATA_BITS-1:0]),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count_unused)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_    (rst_),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_sh_q),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count_unused)
  );

endmodule

// File: tb/tb_apb_uart_v2.sv
// Directed bench for apb_uart_v2: registers, TX framing, loopback RX, overflow, frame error, glitch, parity.
module tb_apb_uart_v2;

  logic        clk = 1'b0;
  logic        rst_;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        psel, penable, pwrite;
  logic        urxd, utxd, uart_int;
  logic        loop_en, urxd_drv;
  logic [31:0] rd;
  logic [8:0]  txexp;
  int          errors = 0;
  int          checks = 0;
  int          n;

  assign urxd = loop_en ? utxd : urxd_drv;
  always #5 clk = ~clk;

  apb_uart_v2 dut (
    .clk        (clk),
    .rst_       (rst_),
    .paddr_i    (paddr),
    .pwdata_i   (pwdata),
    .prdata_o   (prdata),
    .psel_i     (psel),
    .penable_i  (penable),
    .pwrite_i   (pwrite),
    .urxd_i     (urxd),
    .utxd_o     (utxd),
    .uart_int_o (uart_int)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    cyc(1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    cyc(1);
    penable = 1'b1;
    cyc(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    cyc(1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    cyc(1);
    penable = 1'b1;
    d = prdata;
    cyc(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Drives one frame on urxd at BAUD=4 (64 clocks per bit)
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic has_par, input logic par_b);
    urxd_drv = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      urxd_drv = b[i];
      cyc(64);
    end
    if (has_par) begin
      urxd_drv = par_b;
      cyc(64);
    end
    urxd_drv = stop_b;
    cyc(64);
    urxd_drv = 1'b1;
  endtask

  task automatic wait_tx_fall(input string tag);
    n = 0;
    while (utxd !== 1'b0 && n < 400) begin
      cyc(1);
      n++;
    end
    check(tag, {31'b0, utxd}, 32'h0);
  endtask

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    loop_en = 1'b0; urxd_drv = 1'b1; rst_ = 1'b0;
    cyc(3);
    check("rst_utxd", {31'b0, utxd}, 32'h1);
    check("rst_int", {31'b0, uart_int}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    rst_ = 1'b1;
    cyc(2);
    apb_read(4'h4, rd); check("rst_status", rd, 32'h05);
    apb_read(4'h8, rd); check("rst_ctrl", rd, 32'h0);
    apb_read(4'hC, rd); check("rst_baud", rd, 32'h1);

    apb_write(4'hC, 32'h0); apb_read(4'hC, rd); check("baud_zero_is_one", rd, 32'h1);
    apb_write(4'hC, 32'h4); apb_read(4'hC, rd); check("baud_four", rd, 32'h4);
    apb_write(4'h8, 32'h7F); apb_read(4'h8, rd);
`ifdef UART_PARITY_EN
    check("ctrl_mask", rd, 32'h7F);
`else
    check("ctrl_mask", rd, 32'h1F);
`endif
    apb_write(4'h8, 32'h08); check("int_tx_empty", {31'b0, uart_int}, 32'h1);
    apb_write(4'h8, 32'h00); check("int_masked", {31'b0, uart_int}, 32'h0);

    // Transmit 0xA5 and measure the frame on the line
    apb_write(4'h8, 32'h01);
    apb_write(4'h0, 32'hA5);
    wait_tx_fall("tx_start_seen");
    n = 0;
    while (utxd === 1'b0 && n < 200) begin
      cyc(1);
      n++;
    end
    check("tx_start_len", n, 32'd64);
    txexp = {1'b1, 8'hA5};
    cyc(32);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tx_bit%0d", i), {31'b0, utxd}, {31'b0, txexp[i]});
      cyc(64);
    end
    check("tx_idle_high", {31'b0, utxd}, 32'h1);
    apb_read(4'h4, rd); check("tx_done_status", rd, 32'h05);

    // Loopback two back-to-back frames
    loop_en = 1'b1;
    apb_write(4'h8, 32'h03);
    apb_write(4'h0, 32'h3C);
    apb_write(4'h0, 32'hFF);
    cyc(1500);
    apb_write(4'h8, 32'h07);
    check("int_rx_avail", {31'b0, uart_int}, 32'h1);
    apb_write(4'h8, 32'h03);
    apb_write(4'h8, 32'h07);
    apb_read(4'h0, rd); check("lb_byte0", rd, 32'h3C);
    apb_read(4'h0, rd); check("lb_byte1", rd, 32'hFF);
    apb_read(4'h0, rd); check("lb_empty_read", rd, 32'h0);
    check("int_rx_drained", {31'b0, uart_int}, 32'h0);
    apb_read(4'h4, rd); check("lb_status", rd, 32'h05);

    // Fill TX FIFO with the transmitter off, then send 17 frames into a 16-deep RX FIFO
    apb_write(4'h8, 32'h02);
    for (int i = 0; i < 17; i++) apb_write(4'h0, i);
    apb_read(4'h4, rd); check("tx_full_status", rd, 32'h06);
    apb_write(4'h8, 32'h03);
    cyc(20);
    apb_write(4'h0, 32'h11);
    cyc(11400);
    apb_read(4'h4, rd); check("ovr_status", rd, 32'h49);
    apb_write(4'h4, 32'h40);
    apb_read(4'h4, rd); check("ovr_w1c", rd, 32'h09);
    apb_read(4'h0, rd); check("ovr_first", rd, 32'h00);
    for (int i = 1; i < 16; i++) apb_read(4'h0, rd);
    check("ovr_last", rd, 32'h0F);
    apb_read(4'h4, rd); check("ovr_drained", rd, 32'h05);

    // Stop bit held low
    loop_en = 1'b0;
    apb_write(4'h8, 32'h02);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    cyc(100);
    apb_read(4'h4, rd); check("frame_err_status", rd, 32'h25);
    apb_write(4'h8, 32'h12);
    check("int_err", {31'b0, uart_int}, 32'h1);
    apb_write(4'h4, 32'h20);
    check("int_err_cleared", {31'b0, uart_int}, 32'h0);
    apb_read(4'h4, rd); check("frame_err_w1c", rd, 32'h05);

    // Three-tick low glitch, then a clean frame
    urxd_drv = 1'b0;
    cyc(12);
    urxd_drv = 1'b1;
    cyc(200);
    apb_read(4'h4, rd); check("glitch_status", rd, 32'h05);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    cyc(100);
    apb_read(4'h0, rd); check("after_glitch_byte", rd, 32'h5A);

`ifdef UART_PARITY_EN
    loop_en = 1'b1;
    apb_write(4'h8, 32'h43);
    apb_write(4'h0, 32'h07);
    wait_tx_fall("par_tx_start");
    cyc(32 + 64 * 9);
    check("par_tx_bit", {31'b0, utxd}, 32'h1);
    cyc(300);
    apb_read(4'h0, rd); check("par_lb_byte", rd, 32'h07);
    apb_read(4'h4, rd); check("par_lb_status", rd, 32'h05);
    loop_en = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    cyc(100);
    apb_read(4'h4, rd); check("par_err_status", rd, 32'h11);
    apb_read(4'h0, rd); check("par_err_byte", rd, 32'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
